// File: rtl/conv_scheduler.sv
// Address/tap sequencer for a 3x3 convolution over an 8x8 map (6x6 outputs).
// A tag delay line tracks MAC latency so out_valid marks each final result.
module conv_scheduler #(
  parameter int MAC_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       hold,
  output logic       rd_en,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  output logic [3:0] tap,
  output logic       mac_clr,
  output logic       out_valid,
  output logic [2:0] out_row,
  output logic [2:0] out_col,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] orow_q, orow_d;
  logic [2:0] ocol_q, ocol_d;
  logic [1:0] ky_q, ky_d;
  logic [1:0] kx_q, kx_d;
  logic [2:0] drain_q, drain_d;
  logic       last_tap;

  logic       tag_vld_q [MAC_LAT];
  logic [2:0] tag_row_q [MAC_LAT];
  logic [2:0] tag_col_q [MAC_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      orow_q  <= '0;
      ocol_q  <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          orow_d  = '0;
          ocol_d  = '0;
          ky_d    = '0;
          kx_d    = '0;
        end
      end
      S_RUN: begin
        if (!hold) begin
          rd_en = 1'b1;
          // Raster scan: kx fastest, then ky, then output column, then row.
          if (kx_q != 2'd2) begin
            kx_d = kx_q + 2'd1;
          end else begin
            kx_d = '0;
            if (ky_q != 2'd2) begin
              ky_d = ky_q + 2'd1;
            end else begin
              ky_d = '0;
              if (ocol_q != 3'd5) begin
                ocol_d = ocol_q + 3'd1;
              end else begin
                ocol_d = '0;
                if (orow_q != 3'd5) begin
                  orow_d = orow_q + 3'd1;
                end else begin
                  orow_d  = '0;
                  drain_d = '0;
                  state_d = S_DRAIN;
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(MAC_LAT - 1)) state_d = S_DONE;
        else drain_d = drain_q + 3'd1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign rd_row   = orow_q + {1'b0, ky_q};
  assign rd_col   = ocol_q + {1'b0, kx_q};
  assign tap      = ({2'b00, ky_q} * 4'd3) + {2'b00, kx_q};
  assign mac_clr  = rd_en && (ky_q == 2'd0) && (kx_q == 2'd0);
  assign last_tap = rd_en && (ky_q == 2'd2) && (kx_q == 2'd2);

  // Tag line shifts every cycle; hold only stalls issue, not the MAC pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_row_q[i] <= '0;
        tag_col_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= last_tap;
      tag_row_q[0] <= last_tap ? orow_q : 3'd0;
      tag_col_q[0] <= last_tap ? ocol_q : 3'd0;
      for (int i = 1; i < MAC_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_row_q[i] <= tag_row_q[i-1];
        tag_col_q[i] <= tag_col_q[i-1];
      end
    end
  end

  assign out_valid = tag_vld_q[MAC_LAT-1];
  assign out_row   = tag_row_q[MAC_LAT-1];
  assign out_col   = tag_col_q[MAC_LAT-1];

endmodule
